// File: rtl/board_mmio_hub.sv
// board_mmio_hub: dmem address decode into a RAM pass-through window and an MMIO
// window with board registers, a debounced sensor snapshot, a sticky event
// register and a turn handshake.
// Optional feature macro: BOARD_HUB_IRQ_EN (registered event interrupt on irq).
module board_mmio_hub #(
    parameter int unsigned     DATA_W          = 32,
    parameter int unsigned     ADDR_W          = 12,
    parameter logic [ADDR_W-1:0] MMIO_BASE     = 12'hF00,
    parameter int unsigned     NUM_BOARDS      = 4,
    parameter int unsigned     SENSOR_W        = 32,
    parameter int unsigned     DEBOUNCE_CYCLES = 20000
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         wren,
    input  logic [ADDR_W-1:0]            address_dmem,
    input  logic [DATA_W-1:0]            data,
    output logic [DATA_W-1:0]            q_dmem,
    output logic                         ram_wren,
    input  logic [DATA_W-1:0]            ram_q,
    input  logic [SENSOR_W-1:0]          sensor_in,
    input  logic                         turn_req,
    output logic [NUM_BOARDS*DATA_W-1:0] board_out,
    output logic [SENSOR_W-1:0]          sensor_stable,
    output logic                         turn_done,
    output logic                         irq
);

    localparam int unsigned       CNT_W      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX    = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_FIRE   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [ADDR_W-1:0] OFF_SENSOR = ADDR_W'(NUM_BOARDS);
    localparam logic [ADDR_W-1:0] OFF_EVENT  = ADDR_W'(NUM_BOARDS + 1);
    localparam logic [ADDR_W-1:0] OFF_TURN   = ADDR_W'(NUM_BOARDS + 2);

    logic                    is_mmio_c;
    logic [ADDR_W-1:0]       off_c;
    logic                    mmio_wr_c;
    logic                    mmio_rd_c;
    logic                    event_rd_c;
    logic                    turn_wr_c;
    logic                    stable_upd_c;
    logic [DATA_W-1:0]       rd_c;

    logic [DATA_W-1:0]       board_q [NUM_BOARDS];
    logic                    sel_mmio_q;
    logic [DATA_W-1:0]       rd_q;
    logic [SENSOR_W-1:0]     sync1_q;
    logic [SENSOR_W-1:0]     sync2_q;
    logic [SENSOR_W-1:0]     cand_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    sensor_changed_q;
    logic                    turn_pending_q;

    // Address decode; the RAM only sees writes that fall below the MMIO window.
    assign is_mmio_c    = (address_dmem >= MMIO_BASE);
    assign off_c        = address_dmem - MMIO_BASE;
    assign mmio_wr_c    = wren & is_mmio_c;
    assign mmio_rd_c    = ~wren & is_mmio_c;
    assign event_rd_c   = mmio_rd_c && (off_c == OFF_EVENT);
    assign turn_wr_c    = mmio_wr_c && (off_c == OFF_TURN) && data[0];
    assign ram_wren     = wren & ~is_mmio_c;

    // Accept the candidate only if it has been stable for the full window.
    assign stable_upd_c = (sync2_q == cand_q) && (cnt_q == CNT_FIRE) &&
                          (cand_q != sensor_stable);

    // MMIO read-data mux.
    always_comb begin
        rd_c = '0;
        for (int k = 0; k < int'(NUM_BOARDS); k++) begin
            if (off_c == ADDR_W'(k)) begin
                rd_c = board_q[k];
            end
        end
        if (off_c == OFF_SENSOR) begin
            rd_c[SENSOR_W-1:0] = sensor_stable;
        end else if (off_c == OFF_EVENT) begin
            rd_c[1:0] = {turn_pending_q, sensor_changed_q};
        end else if (off_c == OFF_TURN) begin
            rd_c[0] = turn_pending_q;
        end
    end

    // Board registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < int'(NUM_BOARDS); k++) begin
                board_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < int'(NUM_BOARDS); k++) begin
                if (mmio_wr_c && (off_c == ADDR_W'(k))) begin
                    board_q[k] <= data;
                end
            end
        end
    end

    for (genvar g = 0; g < int'(NUM_BOARDS); g++) begin : g_board_out
        assign board_out[g*DATA_W +: DATA_W] = board_q[g];
    end

    // Read pipeline; select resets to MMIO so q_dmem is 0 during reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sel_mmio_q <= 1'b1;
            rd_q       <= '0;
        end else begin
            sel_mmio_q <= is_mmio_c;
            rd_q       <= rd_c;
        end
    end

    assign q_dmem = sel_mmio_q ? rd_q : ram_q;

    // Sensor synchroniser and debounce.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            cand_q        <= '0;
            cnt_q         <= '0;
            sensor_stable <= '0;
        end else begin
            sync1_q <= sensor_in;
            sync2_q <= sync1_q;
            if (sync2_q != cand_q) begin
                cand_q <= sync2_q;
                cnt_q  <= '0;
            end else if (cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (stable_upd_c) begin
                sensor_stable <= cand_q;
            end
        end
    end

    // Sticky flags (set beats clear) and the turn_done pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sensor_changed_q <= 1'b0;
            turn_pending_q   <= 1'b0;
            turn_done        <= 1'b0;
        end else begin
            sensor_changed_q <= stable_upd_c | (sensor_changed_q & ~event_rd_c);
            turn_pending_q   <= turn_req | (turn_pending_q & ~(event_rd_c | turn_wr_c));
            turn_done        <= turn_wr_c;
        end
    end

`ifdef BOARD_HUB_IRQ_EN
    // Interrupt follows the pending flags one cycle later.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            irq <= 1'b0;
        end else begin
            irq <= sensor_changed_q | turn_pending_q;
        end
    end
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_board_mmio_hub.sv
// Scoreboard bench for board_mmio_hub: reads push expected q_dmem values,
// a negedge monitor pops and compares one cycle after each read is issued.
module tb_board_mmio_hub;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned NB     = 4;
    localparam int unsigned SW     = 32;
    localparam int unsigned DB     = 8;

    logic                   clock = 1'b0;
    logic                   reset;
    logic                   wren;
    logic [ADDR_W-1:0]      address_dmem;
    logic [DATA_W-1:0]      data;
    logic [DATA_W-1:0]      q_dmem;
    logic                   ram_wren;
    logic [DATA_W-1:0]      ram_q;
    logic [SW-1:0]          sensor_in;
    logic                   turn_req;
    logic [NB*DATA_W-1:0]   board_out;
    logic [SW-1:0]          sensor_stable;
    logic                   turn_done;
    logic                   irq;

    board_mmio_hub #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MMIO_BASE(12'hF00),
        .NUM_BOARDS(NB), .SENSOR_W(SW), .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clock(clock), .reset(reset), .wren(wren), .address_dmem(address_dmem),
        .data(data), .q_dmem(q_dmem), .ram_wren(ram_wren), .ram_q(ram_q),
        .sensor_in(sensor_in), .turn_req(turn_req), .board_out(board_out),
        .sensor_stable(sensor_stable), .turn_done(turn_done), .irq(irq)
    );

    always #5 clock = ~clock;

    // Synchronous RAM model with 1-cycle latency and an address-derived pattern.
    always @(posedge clock) ram_q <= {20'hCAFE0, address_dmem};

    int             compared   = 0;
    int             mismatched = 0;
    logic [31:0]    exp_q[$];
    string          nm_q[$];
    logic           issue   = 1'b0;
    logic           issue_d = 1'b0;
    logic [127:0]   bexp;

    always @(posedge clock) issue_d <= issue;

    // Monitor: one cycle after a read was issued, q_dmem must match the head.
    always @(negedge clock) begin
        if (issue_d) begin
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL read_unexpected: q_dmem=%h with no expected value", q_dmem);
            end else begin
                logic [31:0] e;
                string       n;
                e = exp_q.pop_front();
                n = nm_q.pop_front();
                if (q_dmem !== e) begin
                    mismatched++;
                    $display("FAIL %s: q_dmem=%h expected %h", n, q_dmem, e);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic exp_ram_wren);
        address_dmem = a;
        data         = d;
        wren         = 1'b1;
        #1 chk("ram_wren", 128'(ram_wren), 128'(exp_ram_wren));
        @(negedge clock);
        wren         = 1'b0;
        address_dmem = 12'h000;
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] e, input string nm);
        address_dmem = a;
        wren         = 1'b0;
        issue        = 1'b1;
        exp_q.push_back(e);
        nm_q.push_back(nm);
        @(negedge clock);
        issue        = 1'b0;
        address_dmem = 12'h000;
    endtask

    initial begin
        reset        = 1'b0;
        wren         = 1'b0;
        address_dmem = 12'h000;
        data         = '0;
        sensor_in    = '0;
        turn_req     = 1'b0;
        bexp         = '0;
        cyc(2);
        chk("rst_q_dmem", 128'(q_dmem), 128'h0);
        chk("rst_board_out", 128'(board_out), 128'h0);
        chk("rst_sensor_stable", 128'(sensor_stable), 128'h0);
        chk("rst_turn_done", 128'(turn_done), 128'h0);
        chk("rst_irq", 128'(irq), 128'h0);
        reset = 1'b1;
        cyc(2);

        // Board register write/read and RAM window.
        wr(12'hF01, 32'hA5A5_0001, 1'b0);
        bexp[63:32] = 32'hA5A5_0001;
        chk("board1_after_write", 128'(board_out), bexp);
        rd(12'hF01, 32'hA5A5_0001, "rd_board1");
        wr(12'h010, 32'h1111_2222, 1'b1);
        chk("board_after_ram_write", 128'(board_out), bexp);
        wr(12'hF00, 32'h0000_1234, 1'b0);
        bexp[31:0] = 32'h0000_1234;
        chk("board0_after_write", 128'(board_out), bexp);
        rd(12'h010, 32'hCAFE_0010, "rd_ram");
        rd(12'hF00, 32'h0000_1234, "rd_board0");
        rd(12'hF07, 32'h0, "rd_unmapped");
        wr(12'hF07, 32'hFFFF_FFFF, 1'b0);
        chk("board_after_unmapped_write", 128'(board_out), bexp);

        // Short glitch is filtered.
        sensor_in = 32'h1;
        cyc(5);
        sensor_in = 32'h0;
        cyc(20);
        chk("glitch_filtered", 128'(sensor_stable), 128'h0);
        rd(12'hF05, 32'h0, "event_after_glitch");

        // Stable change is accepted and flagged once.
        sensor_in = 32'h1;
        cyc(12);
        cyc(4);
        chk("sensor_accepted", 128'(sensor_stable), 128'h1);
`ifdef BOARD_HUB_IRQ_EN
        chk("irq_on_event", 128'(irq), 128'h1);
`else
        chk("irq_tied_low", 128'(irq), 128'h0);
`endif
        rd(12'hF04, 32'h1, "rd_sensor");
        rd(12'hF05, 32'h1, "event_sensor_changed");
        rd(12'hF05, 32'h0, "event_cleared");
        cyc(2);
        chk("irq_after_clear", 128'(irq), 128'h0);

        // turn_req on the same edge as an EVENT read: set wins.
        address_dmem = 12'hF05;
        turn_req     = 1'b1;
        issue        = 1'b1;
        exp_q.push_back(32'h0);
        nm_q.push_back("event_preclear");
        @(negedge clock);
        turn_req     = 1'b0;
        issue        = 1'b0;
        address_dmem = 12'h000;
        rd(12'hF06, 32'h1, "turn_rd_pending");
        rd(12'hF06, 32'h1, "turn_rd_no_clear");
        rd(12'hF05, 32'h2, "event_turn_pending");
        rd(12'hF05, 32'h0, "event_turn_cleared");

        // TURN write: pulse, pending cleared.
        turn_req = 1'b1;
        cyc(1);
        turn_req = 1'b0;
        wr(12'hF06, 32'h1, 1'b0);
        chk("turn_done_pulse", 128'(turn_done), 128'h1);
        cyc(1);
        chk("turn_done_single", 128'(turn_done), 128'h0);
        rd(12'hF06, 32'h0, "turn_pending_cleared");
        wr(12'hF06, 32'h0, 1'b0);
        chk("turn_done_data0_zero", 128'(turn_done), 128'h0);
        cyc(1);
        chk("turn_done_still_zero", 128'(turn_done), 128'h0);

        // Back-to-back TURN writes.
        address_dmem = 12'hF06;
        data         = 32'h1;
        wren         = 1'b1;
        cyc(1);
        chk("turn_done_b2b_first", 128'(turn_done), 128'h1);
        cyc(1);
        wren         = 1'b0;
        address_dmem = 12'h000;
        chk("turn_done_b2b_second", 128'(turn_done), 128'h1);
        cyc(1);
        chk("turn_done_b2b_end", 128'(turn_done), 128'h0);

        // Reset mid-debounce with non-zero board state.
        sensor_in = 32'h2;
        cyc(4);
        reset = 1'b0;
        #1;
        chk("midrst_board_out", 128'(board_out), 128'h0);
        chk("midrst_sensor_stable", 128'(sensor_stable), 128'h0);
        chk("midrst_q_dmem", 128'(q_dmem), 128'h0);
        chk("midrst_irq", 128'(irq), 128'h0);
        cyc(1);
        reset     = 1'b1;
        sensor_in = 32'h0;
        cyc(20);
        chk("post_rst_sensor", 128'(sensor_stable), 128'h0);
        chk("post_rst_irq", 128'(irq), 128'h0);
        chk("post_rst_turn_done", 128'(turn_done), 128'h0);
        rd(12'hF05, 32'h0, "post_rst_event");

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) cyc(1);
        cyc(1);
        if (exp_q.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL scoreboard_drain: %0d reads pending, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/board_mmio_hub.md
# board_mmio_hub

Parametrised memory-mapped I/O hub between the processor data-memory port and the checkers board hardware. Decodes the processor dmem address into a RAM pass-through window and an MMIO window holding NUM_BOARDS writable board registers, a debounced sensor snapshot, a sticky event register and a turn handshake. Sits where the single-purpose memory manager sat; its board outputs feed the light controller and it consumes raw sensor-matrix bits.

## Interface
- DATA_W, 32: processor data width.
- ADDR_W, 12: dmem word-address width.
- MMIO_BASE, 12'hF00: first MMIO word address; addresses below go to RAM.
- NUM_BOARDS, 4: number of RW board registers, from 1 to 8.
- SENSOR_W, 32: raw sensor width, at most DATA_W.
- DEBOUNCE_CYCLES, 20000: stable cycles required before a sensor change is accepted; must be at least 1.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- wren  in  1  processor dmem write enable.
- address_dmem  in  ADDR_W  processor word address.
- data  in  DATA_W  processor write data.
- q_dmem  out  DATA_W  read data returned to the processor.
- ram_wren  out  1  RAM write enable; asserted only for RAM-window writes.
- ram_q  in  DATA_W  RAM read data; the RAM is synchronous with 1-cycle latency.
- sensor_in  in  SENSOR_W  raw, asynchronous sensor bits.
- turn_req  in  1  single-cycle pulse meaning the player has ended a turn.
- board_out  out  NUM_BOARDS*DATA_W  board registers; register k occupies bits [k*DATA_W +: DATA_W].
- sensor_stable  out  SENSOR_W  debounced sensor word.
- turn_done  out  1  single-cycle pulse meaning the CPU has finished its move.
- irq  out  1  event-pending interrupt; see Configuration.

## Operation
- The MMIO offset is off = address_dmem - MMIO_BASE.
- The hub is in MMIO mode when address_dmem >= MMIO_BASE. The address and data buses pass straight to the RAM, which is external.
- Offsets 0..NUM_BOARDS-1 are BOARD[k]:
  - Read/write.
  - A write updates the register on the next rising edge.
- Offset NUM_BOARDS is SENSOR, read-only. It returns sensor_stable zero-extended to DATA_W.
- Offset NUM_BOARDS+1 is EVENT, read-to-clear:
  - bit0 = sensor_changed.
  - bit1 = turn_pending.
  - All other bits read 0.
- Offset NUM_BOARDS+2 is TURN:
  - A write with data[0]=1 pulses turn_done for one cycle.
  - A read returns bit0 = turn_pending, without clearing it.
- Any other MMIO offset reads 0. Writes to it are ignored.
- Sensor path:
  - Two-flop synchroniser, then a candidate register and a counter of width $clog2(DEBOUNCE_CYCLES+1).
  - When synced != candidate: candidate <= synced and the counter goes to 0.
  - Otherwise the counter saturates at DEBOUNCE_CYCLES.
  - When the counter reaches DEBOUNCE_CYCLES-1 and candidate != sensor_stable: sensor_stable <= candidate and sensor_changed is set.
- turn_pending:
  - Set by turn_req.
  - Cleared by a TURN write with data[0]=1 or by an EVENT read.
- Simultaneous set and clear on the same edge: the set wins, so the flag stays 1. An event arriving during the clearing read is therefore never lost.

## Timing
- Reads have 1-cycle latency. The select (RAM or MMIO register) and the MMIO read value are registered on the edge that samples the address. q_dmem shows the result in the following cycle, aligned with ram_q.
- A read-to-clear takes effect on the same edge that captures the read value. The captured value is the pre-clear contents.
- ram_wren = wren & ~MMIO, combinational, with no added latency.
- turn_done rises on the edge after the TURN write is sampled and lasts exactly one cycle. Back-to-back writes give back-to-back pulses.
- Sensor latency: 2 synchroniser cycles + DEBOUNCE_CYCLES cycles from a stable input change to the sensor_stable update. Glitches shorter than DEBOUNCE_CYCLES never propagate.
- Values while reset is low: q_dmem, board_out, sensor_stable, the synchroniser, candidate, counter, flags, turn_done and irq are all 0.
- A reset asserted mid-debounce or mid-pulse clears everything immediately. No pulse is emitted after reset is released.

## Configuration
- BOARD_HUB_IRQ_EN defined: irq is registered, equal to sensor_changed | turn_pending, lagging each flag by one cycle.
- BOARD_HUB_IRQ_EN undefined: irq is constant 0 and the irq flop is not synthesised. The rest of the behaviour is identical; the processor polls EVENT.

## Test plan
- Write 32'hA5A5_0001 to 12'hF01 (BOARD[1]), then read 12'hF01 → board_out[63:32]=32'hA5A5_0001 after the write edge, and q_dmem=32'hA5A5_0001 one cycle after the read address.
- Write 12'h010 with wren=1 → ram_wren=1 and board_out unchanged. Write 12'hF00 → ram_wren=0.
- sensor_in goes 0→32'h1 for 5 cycles, then returns to 0 (DEBOUNCE_CYCLES=8) → sensor_stable stays 0. Hold it for 12 cycles → sensor_stable=1 and EVENT reads 32'h1, then a second EVENT read returns 0.
- turn_req pulses on the same edge as an EVENT read → the read returns bit1 per the pre-clear state, turn_pending remains 1, and the next EVENT read returns 32'h2.
- Write 32'h1 to 12'hF06 (TURN, NUM_BOARDS=4) → a one-cycle turn_done pulse and turn_pending cleared. Write 32'h0 → no pulse.
- Assert reset mid-debounce with a non-zero board register → all outputs 0 immediately. With BOARD_HUB_IRQ_EN defined, irq stays 0 until a new event occurs.
